// File: rtl/input_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : input_port_ctrl
// Purpose  : Router input-port controller. Pops flits from the port FIFO,
//            XY-routes the head flit, requests the allocator and streams the
//            granted packet to the crossbar.
// Revision : 1.0 - initial release
// ============================================================================
module input_port_ctrl #(
    parameter int FLIT_W  = 32,
    parameter int COORD_W = 4,
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              FIFO_EMPTY,
    output logic              FIFO_RD_EN,
    input  logic [FLIT_W-1:0] FIFO_DATA,
    output logic [4:0]        REQ,
    input  logic              GNT,
    output logic [FLIT_W-1:0] OUT_FLIT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              ERR
);

    localparam logic [COORD_W-1:0] c_cur_x = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] c_cur_y = COORD_W'(CUR_Y);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    state_t              r_state;
    logic [FLIT_W-1:0]   r_skid0;
    logic [FLIT_W-1:0]   r_skid1;
    logic [1:0]          r_occ;
    logic                r_pend;
    logic [4:0]          r_req;
    logic                r_err;

    logic [1:0]          w_ftype;
    logic                w_front_head;
    logic                w_front_tail;
    logic                w_has;
    logic                w_xfer;
    logic                w_drop;
    logic                w_pop;
    logic [1:0]          w_fill;
    logic                w_wr_front;
    logic [COORD_W-1:0]  w_dst_x;
    logic [COORD_W-1:0]  w_dst_y;
    logic [4:0]          w_route;

    // Type 01/11 start a packet, 10/11 end one.
    assign w_ftype      = r_skid0[FLIT_W-1 -: 2];
    assign w_front_head = w_ftype[0];
    assign w_front_tail = w_ftype[1];
    assign w_has        = (r_occ != 2'd0);

    assign OUT_VALID = (r_state == ST_ACTIVE) && w_has;
    assign w_xfer    = OUT_VALID && OUT_READY;
    assign w_drop    = (r_state == ST_IDLE) && w_has && !w_front_head;
    assign w_pop     = w_xfer || w_drop;

    // Occupancy after this edge; the read-enable rule keeps occ+pend <= 2.
    assign w_fill     = r_occ + {1'b0, r_pend} - {1'b0, w_pop};
    assign w_wr_front = (r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop);
    assign FIFO_RD_EN = RSTn && !FIFO_EMPTY && (w_fill < 2'd2);

    assign OUT_FLIT = r_skid0;
    assign REQ      = r_req;
    assign ERR      = r_err;

    assign w_dst_x = r_skid0[COORD_W-1:0];
    assign w_dst_y = r_skid0[2*COORD_W-1:COORD_W];

    always_comb begin
        w_route = 5'b00001;
        if (w_dst_x > c_cur_x)
            w_route = 5'b00100;
        else if (w_dst_x < c_cur_x)
            w_route = 5'b10000;
        else if (w_dst_y > c_cur_y)
            w_route = 5'b00010;
        else if (w_dst_y < c_cur_y)
            w_route = 5'b01000;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
            r_skid0 <= '0;
            r_skid1 <= '0;
            r_occ   <= 2'd0;
            r_pend  <= 1'b0;
            r_req   <= 5'd0;
            r_err   <= 1'b0;
        end else begin
            r_err  <= w_drop;
            r_pend <= FIFO_RD_EN;
            r_occ  <= w_fill;

            if (w_pop)
                r_skid0 <= r_skid1;
            // Returning read data lands behind whatever survives the pop.
            if (r_pend) begin
                if (w_wr_front)
                    r_skid0 <= FIFO_DATA;
                else
                    r_skid1 <= FIFO_DATA;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_has && w_front_head) begin
                        r_req   <= w_route;
                        r_state <= ST_WAIT_GNT;
                    end
                end
                ST_WAIT_GNT: begin
                    if (GNT)
                        r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (w_xfer && w_front_tail) begin
                        r_req   <= 5'd0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_req   <= 5'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
